// File: rtl/dt_pkg.sv
// rtl/dt_pkg.sv - shared DT image geometry, bus widths and packer state type
package dt_pkg;

  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int RES_AW = 14;
  localparam int STI_AW = 10;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    PK_IDLE  = 2'd0,
    PK_RUN   = 2'd1,
    PK_DRAIN = 2'd2,
    PK_FIN   = 2'd3
  } pk_state_e;

endpackage

// File: rtl/dt_bit_packer.sv
// rtl/dt_bit_packer.sv - MSB-first 16-pixel bit packer with 4-bit fill count
module dt_bit_packer
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              pix_bit,
  input  logic              valid,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  // Only 15 bits are stored; the 16th bit completes the word combinationally
  // so the word is presented on the same edge its last pixel arrives.
  logic [WORD_W-2:0] sr;
  logic [3:0]        fill;

  assign word       = {sr, pix_bit};
  assign word_valid = valid && (fill == 4'd15);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sr   <= '0;
      fill <= '0;
    end else if (valid) begin
      sr   <= word[WORD_W-2:0];
      fill <= fill + 4'd1;
    end
  end

endmodule

// File: rtl/dt_res_packer.sv
// rtl/dt_res_packer.sv - streams the DT result map, thresholds and packs it 16 pixels per word
module dt_res_packer
  import dt_pkg::*;
#(
  parameter int IMG_W  = dt_pkg::IMG_W,
  parameter int IMG_H  = dt_pkg::IMG_H,
  parameter int THRESH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              res_rd,
  output logic [RES_AW-1:0] res_addr,
  input  logic [7:0]        res_di,
  output logic              pk_wr,
  output logic [STI_AW-1:0] pk_addr,
  output logic [WORD_W-1:0] pk_do,
  output logic [14:0]       obj_cnt,
  output logic [7:0]        max_dist
);

  localparam int                N          = IMG_W * IMG_H;
  localparam logic [RES_AW-1:0] LAST_ISSUE = RES_AW'(N - 2);
  localparam logic [7:0]        THR        = 8'(THRESH);

  pk_state_e         state;
  logic              accept;
  logic              pix_hit;
  logic [WORD_W-1:0] word;
  logic              word_valid;

  assign accept  = (state == PK_IDLE) && start;
  assign pix_hit = (res_di >= THR);

  // res_rd high means res_di holds the pixel at res_addr this cycle.
  dt_bit_packer u_pack (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept),
    .pix_bit    (pix_hit),
    .valid      (res_rd),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PK_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      res_rd   <= 1'b0;
      res_addr <= '0;
      pk_wr    <= 1'b0;
      pk_addr  <= '0;
      pk_do    <= '0;
      obj_cnt  <= '0;
      max_dist <= '0;
    end else begin
      pk_wr <= word_valid;
      if (word_valid) begin
        pk_addr <= res_addr[RES_AW-1:4];
        pk_do   <= word;
      end

      if (res_rd) begin
        obj_cnt <= obj_cnt + 15'(pix_hit);
        if (res_di > max_dist) max_dist <= res_di;
      end

      case (state)
        PK_IDLE: begin
          if (start) begin
            state    <= PK_RUN;
            res_rd   <= 1'b1;
            res_addr <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            obj_cnt  <= '0;
            max_dist <= '0;
          end
        end
        PK_RUN: begin
          res_addr <= res_addr + 1'b1;
          if (res_addr == LAST_ISSUE) state <= PK_DRAIN;
        end
        // Address N-1 is on the bus; its pixel is consumed this edge.
        PK_DRAIN: begin
          res_rd <= 1'b0;
          state  <= PK_FIN;
        end
        PK_FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= PK_IDLE;
        end
        default: state <= PK_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dt_res_packer.sv
// tb/tb_dt_res_packer.sv - self-checking bench for dt_res_packer (THRESH=1 and THRESH=3 instances)
module tb_dt_res_packer;

  localparam int N = 16384;
  localparam int W = 1024;

  logic clk = 1'b0;
  logic reset, start;
  always #5 clk = ~clk;

  logic        busy_a, done_a, res_rd_a, pk_wr_a;
  logic [13:0] res_addr_a;
  logic [7:0]  res_di_a = 8'd0;
  logic [9:0]  pk_addr_a;
  logic [15:0] pk_do_a;
  logic [14:0] obj_a;
  logic [7:0]  max_a;

  logic        busy_b, done_b, res_rd_b, pk_wr_b;
  logic [13:0] res_addr_b;
  logic [7:0]  res_di_b = 8'd0;
  logic [9:0]  pk_addr_b;
  logic [15:0] pk_do_b;
  logic [14:0] obj_b;
  logic [7:0]  max_b;

  dt_res_packer #(.IMG_W(128), .IMG_H(128), .THRESH(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .busy(busy_a), .done(done_a),
    .res_rd(res_rd_a), .res_addr(res_addr_a), .res_di(res_di_a),
    .pk_wr(pk_wr_a), .pk_addr(pk_addr_a), .pk_do(pk_do_a),
    .obj_cnt(obj_a), .max_dist(max_a)
  );

  dt_res_packer #(.IMG_W(128), .IMG_H(128), .THRESH(3)) dut_b (
    .clk(clk), .reset(reset), .start(start), .busy(busy_b), .done(done_b),
    .res_rd(res_rd_b), .res_addr(res_addr_b), .res_di(res_di_b),
    .pk_wr(pk_wr_b), .pk_addr(pk_addr_b), .pk_do(pk_do_b),
    .obj_cnt(obj_b), .max_dist(max_b)
  );

  logic [7:0]  mem [N];
  logic [15:0] got_a [W];
  logic [15:0] got_b [W];
  int wr_a, wr_b, ord_a, ord_b;
  int total = 0;
  int bad   = 0;

  // res RAM: address presented after a rising edge, data ready for the next rising edge
  always @(negedge clk) begin
    if (res_rd_a) res_di_a <= mem[res_addr_a];
    if (res_rd_b) res_di_b <= mem[res_addr_b];
  end

  always @(negedge clk) begin
    if (pk_wr_a) begin
      if (int'(pk_addr_a) != wr_a) ord_a++;
      got_a[pk_addr_a] = pk_do_a;
      wr_a++;
    end
    if (pk_wr_b) begin
      if (int'(pk_addr_b) != wr_b) ord_b++;
      got_b[pk_addr_b] = pk_do_b;
      wr_b++;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic logic [15:0] model_word(input int w, input int th);
    logic [15:0] r = '0;
    for (int i = 0; i < 16; i++) r[15-i] = (int'(mem[16*w+i]) >= th);
    return r;
  endfunction

  task automatic clear_capture();
    wr_a = 0; wr_b = 0; ord_a = 0; ord_b = 0;
    for (int i = 0; i < W; i++) begin
      got_a[i] = 'x;
      got_b[i] = 'x;
    end
  endtask

  task automatic fill(input int pat);
    for (int i = 0; i < N; i++) begin
      case (pat)
        1:       mem[i] = 8'd1;
        3:       mem[i] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255))
                                                       : 8'($urandom_range(0, 3));
        default: mem[i] = 8'd0;
      endcase
    end
    if (pat == 2) begin
      mem[0]   = 8'd5;
      mem[N-1] = 8'd9;
      for (int i = 16; i < 32; i++) mem[i] = (i % 2 == 1) ? 8'd3 : 8'd2;
    end
  endtask

  // Launch both instances, optionally re-pulse start mid-run; lat = edges from E0 to done.
  task automatic run(input string tag, input int pulse_at, output int lat);
    clear_capture();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, " busy after start"}, busy_a, 1);
    chk({tag, " res_rd after start"}, res_rd_a, 1);
    chk({tag, " res_addr after start"}, res_addr_a, 0);
    lat = 0;
    while (!done_a && lat < N + 50) begin
      start = (lat == pulse_at);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic verify(input string tag, input int lat);
    int          bw_a = 0, bw_b = 0;
    logic [14:0] eo_a = '0, eo_b = '0;
    logic [7:0]  em = '0;
    for (int i = 0; i < N; i++) begin
      if (mem[i] >= 8'd1) eo_a++;
      if (mem[i] >= 8'd3) eo_b++;
      if (mem[i] > em) em = mem[i];
    end
    for (int w = 0; w < W; w++) begin
      if (got_a[w] !== model_word(w, 1)) bw_a++;
      if (got_b[w] !== model_word(w, 3)) bw_b++;
    end
    chk({tag, " done latency"}, lat, N + 1);
    chk({tag, " done_b"}, done_b, 1);
    chk({tag, " busy low at done"}, busy_a, 0);
    chk({tag, " pk_wr low at done"}, pk_wr_a, 0);
    chk({tag, " writes a"}, wr_a, W);
    chk({tag, " writes b"}, wr_b, W);
    chk({tag, " addr order a"}, ord_a, 0);
    chk({tag, " addr order b"}, ord_b, 0);
    chk({tag, " bad words a"}, bw_a, 0);
    chk({tag, " bad words b"}, bw_b, 0);
    chk({tag, " obj_cnt a"}, obj_a, eo_a);
    chk({tag, " obj_cnt b"}, obj_b, eo_b);
    chk({tag, " max_dist a"}, max_a, em);
    chk({tag, " max_dist b"}, max_b, em);
  endtask

  typedef struct {
    int          pat;
    int          pulse_at;
    int          a_obj;
    int          a_max;
    int          b_obj;
    logic [15:0] a_w0;
    logic [15:0] a_w1;
    logic [15:0] a_wl;
    logic [15:0] b_w1;
  } vec_t;

  initial begin
    vec_t tbl [3];
    int   lat, wr_hold;
    tbl[0] = '{0, 100, 0,     0, 0,  16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[1] = '{1, -1,  16384, 1, 0,  16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};
    tbl[2] = '{2, -1,  18,    9, 10, 16'h8000, 16'hFFFF, 16'h0001, 16'h5555};

    reset = 1'b1; start = 1'b0;
    clear_capture();
    repeat (3) @(negedge clk);
    chk("reset busy", busy_a, 0);
    chk("reset done", done_a, 0);
    chk("reset res_rd", res_rd_a, 0);
    chk("reset pk_wr", pk_wr_a, 0);
    chk("reset res_addr", res_addr_a, 0);
    chk("reset pk_addr", pk_addr_a, 0);
    chk("reset pk_do", pk_do_a, 0);
    chk("reset obj_cnt", obj_a, 0);
    chk("reset max_dist", max_a, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      fill(tbl[k].pat);
      run(tag, tbl[k].pulse_at, lat);
      verify(tag, lat);
      chk({tag, " tbl obj a"}, obj_a, tbl[k].a_obj);
      chk({tag, " tbl max a"}, max_a, tbl[k].a_max);
      chk({tag, " tbl obj b"}, obj_b, tbl[k].b_obj);
      chk({tag, " tbl word0 a"}, got_a[0], tbl[k].a_w0);
      chk({tag, " tbl word1 a"}, got_a[1], tbl[k].a_w1);
      chk({tag, " tbl word1023 a"}, got_a[1023], tbl[k].a_wl);
      chk({tag, " tbl word1 b"}, got_b[1], tbl[k].b_w1);
      repeat (2) @(negedge clk);
      chk({tag, " done holds"}, done_a, 1);
      chk({tag, " obj holds"}, obj_a, tbl[k].a_obj);
    end

    // reset in the middle of a random run, then a clean full run
    fill(3);
    clear_capture();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (500) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset res_rd", res_rd_a, 0);
    chk("midreset pk_wr", pk_wr_a, 0);
    chk("midreset busy", busy_a, 0);
    chk("midreset res_addr", res_addr_a, 0);
    chk("midreset obj_cnt", obj_a, 0);
    wr_hold = wr_a;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("midreset no writes", wr_a, wr_hold);
    chk("midreset stays idle", busy_a, 0);

    run("random", -1, lat);
    verify("random", lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
